// File: rtl/cache_refill_if.sv
// Signal bundle between the cache controller, cache_refill_unit and main_memory.
// The unit itself uses the slave modport; the controller/memory side uses master.
interface cache_refill_if;
    logic         miss_valid;
    logic [31:0]  miss_addr;
    logic         miss_ready;
    logic         mem_read_en;
    logic [31:0]  mem_address;
    logic [127:0] mem_block_in;
    logic         mem_ready;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [127:0] fill_data;
    logic [31:0]  fill_word;
    logic         fill_error;
    logic         busy;

    modport slave (
        input  miss_valid, miss_addr, mem_block_in, mem_ready,
        output miss_ready, mem_read_en, mem_address, fill_valid, fill_addr, fill_data,
               fill_word, fill_error, busy
    );

    modport master (
        output miss_valid, miss_addr, mem_block_in, mem_ready,
        input  miss_ready, mem_read_en, mem_address, fill_valid, fill_addr, fill_data,
               fill_word, fill_error, busy
    );
endinterface

// File: rtl/cache_refill_unit.sv
// Single-outstanding block refill: one read strobe to main_memory, capture, present word to cache.
// Define REFILL_TIMEOUT_EN to compile in the WAIT watchdog (TIMEOUT_CYCLES WAIT cycles max).
module cache_refill_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic           clk,
    input logic           rst,
    cache_refill_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StFill} state_e;

    state_e       state_q, state_d;
    logic [27:0]  addr_q, addr_d;
    logic [1:0]   sel_q, sel_d;
    logic [127:0] data_q, data_d;
    logic         error_q, error_d;
    logic         timeout;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^bus.miss_addr[1:0];

`ifdef REFILL_TIMEOUT_EN
    localparam logic [7:0] WaitLimit = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // High on the last permitted WAIT cycle; mem_ready on that cycle still wins.
    assign timeout = (cnt_q == WaitLimit);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StReq) begin
            cnt_d = '0;
        end else if (state_q == StWait && !bus.mem_ready) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                if (bus.miss_valid) begin
                    state_d = StReq;
                    addr_d  = bus.miss_addr[31:4];
                    sel_d   = bus.miss_addr[3:2];
                end
            end
            StReq: state_d = StWait;
            StWait: begin
                if (bus.mem_ready) begin
                    state_d = StFill;
                    data_d  = bus.mem_block_in;
                    error_d = 1'b0;
                end else if (timeout) begin
                    state_d = StFill;
                    data_d  = '0;
                    error_d = 1'b1;
                end
            end
            StFill: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    assign bus.miss_ready  = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.mem_read_en = (state_q == StReq);
    assign bus.mem_address = {addr_q, 4'h0};
    assign bus.fill_valid  = (state_q == StFill);
    assign bus.fill_addr   = {addr_q, 4'h0};
    assign bus.fill_data   = data_q;
    assign bus.fill_error  = error_q;

    always_comb begin
        bus.fill_word = data_q[31:0];
        unique case (sel_q)
            2'd0: bus.fill_word = data_q[31:0];
            2'd1: bus.fill_word = data_q[63:32];
            2'd2: bus.fill_word = data_q[95:64];
            2'd3: bus.fill_word = data_q[127:96];
            default: bus.fill_word = data_q[31:0];
        endcase
    end

endmodule

// File: tb/tb_cache_refill_unit.sv
// Bench for cache_refill_unit: transaction-level reference model, directed cases, random traffic.
// Timeout cases are built in only when REFILL_TIMEOUT_EN is defined.
module tb_cache_refill_unit;

    localparam int unsigned TimeoutCycles = 4;

    logic clk = 1'b0;
    logic rst;

    cache_refill_if bus ();

    cache_refill_unit #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: word i of the block at aligned address A is A + i.
    function automatic logic [127:0] block_of(input logic [31:0] a);
        return {a + 32'd3, a + 32'd2, a + 32'd1, a};
    endfunction

    int          mem_delay   = 0;   // WAIT cycles before ready; -1 = never answer
    bit          noise       = 1'b0;
    bit          force_ready = 1'b0;
    int          countdown   = -1;
    logic [31:0] req_addr    = '0;

    initial begin
        bus.mem_ready    = 1'b0;
        bus.mem_block_in = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready    = 1'b0;
            bus.mem_block_in = {$urandom, $urandom, $urandom, $urandom};
            if (countdown == 0) begin
                bus.mem_ready    = 1'b1;
                bus.mem_block_in = block_of(req_addr);
                countdown        = -1;
            end else if (countdown > 0) begin
                countdown--;
            end else if (noise && $urandom_range(7) == 0) begin
                bus.mem_ready = 1'b1;
            end
            if (bus.mem_read_en === 1'b1) begin
                req_addr  = bus.mem_address;
                countdown = mem_delay;
            end
            if (force_ready) begin
                bus.mem_ready = 1'b1;
                force_ready   = 1'b0;
            end
        end
    end

    // Reference model in edge timestamps: accept at edge a, strobe during the cycle after a,
    // memory data honoured from edge a+2 on, fill during the cycle after the capture edge.
    int           k = 0;
    int           m_acc = 0;
    bit           m_init = 1'b0, m_busy = 1'b0, m_filled = 1'b0;
    bit           m_rd = 1'b0, m_fv = 1'b0, m_err = 1'b0;
    logic [31:0]  m_addr = '0;
    logic [1:0]   m_sel = '0;
    logic [127:0] m_data = '0;

    always @(posedge clk) begin
        k++;
        m_rd = 1'b0;
        m_fv = 1'b0;
        if (rst) begin
            m_init = 1'b1; m_busy = 1'b0; m_filled = 1'b0;
            m_addr = '0; m_sel = '0; m_data = '0; m_err = 1'b0;
        end else if (!m_busy) begin
            if (bus.miss_valid) begin
                m_busy   = 1'b1;
                m_filled = 1'b0;
                m_acc    = k;
                m_addr   = {bus.miss_addr[31:4], 4'h0};
                m_sel    = bus.miss_addr[3:2];
                m_rd     = 1'b1;
            end
        end else if (m_filled) begin
            m_busy = 1'b0;
        end else if (k >= m_acc + 2) begin
            if (bus.mem_ready) begin
                m_data = bus.mem_block_in; m_err = 1'b0; m_filled = 1'b1; m_fv = 1'b1;
            end
`ifdef REFILL_TIMEOUT_EN
            else if (k - m_acc - 1 == int'(TimeoutCycles)) begin
                m_data = '0; m_err = 1'b1; m_filled = 1'b1; m_fv = 1'b1;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("miss_ready", bus.miss_ready, !m_busy);
            chk("busy", bus.busy, m_busy);
            chk("mem_read_en", bus.mem_read_en, m_rd);
            chk("mem_address", bus.mem_address, m_addr);
            chk("fill_valid", bus.fill_valid, m_fv);
            chk("fill_addr", bus.fill_addr, m_addr);
            chk("fill_data", bus.fill_data, m_data);
            chk("fill_word", bus.fill_word, m_data[m_sel*32 +: 32]);
            chk("fill_error", bus.fill_error, m_err);
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (bus.miss_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("idle_wait", bus.miss_ready, 1'b1);
    endtask

    // lat counts cycles after the accept edge; returns with fill_valid seen (or budget spent).
    task automatic wait_fill(output int lat);
        lat = 1;
        while (bus.fill_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic refill(input string name, input logic [31:0] addr, input int delay,
                          input int exp_lat, input logic [31:0] exp_word, input bit exp_err);
        int lat;
        wait_idle();
        mem_delay      = delay;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = addr;
        @(negedge clk);
        bus.miss_valid = 1'b0;
        bus.miss_addr  = $urandom;
        wait_fill(lat);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_word"}, bus.fill_word, exp_word);
        chk({name, "_addr"}, bus.fill_addr, {addr[31:4], 4'h0});
        chk({name, "_error"}, bus.fill_error, exp_err);
    endtask

    logic [31:0] sweep_addr [4] = '{32'h40, 32'h44, 32'h48, 32'h4C};
    logic [31:0] sweep_word [4] = '{32'h40, 32'h41, 32'h42, 32'h43};

    initial begin
        int lat, t1, t2, g;
        bit acc;
        rst            = 1'b1;
        bus.miss_valid = 1'b0;
        bus.miss_addr  = '0;
        repeat (3) @(negedge clk);
        chk("rst_miss_ready", bus.miss_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_read_en", bus.mem_read_en, 1'b0);
        chk("rst_fill_valid", bus.fill_valid, 1'b0);
        chk("rst_mem_address", bus.mem_address, 32'h0);
        chk("rst_fill_data", bus.fill_data, 128'h0);
        chk("rst_fill_error", bus.fill_error, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        refill("basic", 32'h0000_1234, 0, 3, 32'h1231, 1'b0);
        chk("basic_data", bus.fill_data, 128'h00001233_00001232_00001231_00001230);

        for (int i = 0; i < 4; i++) refill("sweep", sweep_addr[i], 0, 3, sweep_word[i], 1'b0);

        refill("stall", 32'h0000_2008, 5, 8, 32'h2002, 1'b0);
        chk("stall_data", bus.fill_data, block_of(32'h2000));

        // Request raised during WAIT must wait for IDLE.
        wait_idle();
        mem_delay      = 3;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h300;
        @(negedge clk);
        bus.miss_valid = 1'b0;
        @(negedge clk);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h404;
        wait_fill(lat);
        chk("held_first_addr", bus.fill_addr, 32'h300);
        wait_idle();
        @(negedge clk);
        bus.miss_valid = 1'b0;
        wait_fill(lat);
        chk("held_second_addr", bus.fill_addr, 32'h400);
        chk("held_second_word", bus.fill_word, 32'h401);

        // Back-to-back with miss_valid held continuously.
        wait_idle();
        mem_delay      = 0;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h100;
        @(negedge clk);
        bus.miss_addr = 32'h200;
        wait_fill(lat);
        t1 = k;
        chk("b2b_first_addr", bus.fill_addr, 32'h100);
        @(negedge clk);
        @(negedge clk);
        bus.miss_valid = 1'b0;
        wait_fill(lat);
        t2 = k;
        chk("b2b_gap", t2 - t1, 4);
        chk("b2b_second_addr", bus.fill_addr, 32'h200);

`ifdef REFILL_TIMEOUT_EN
        refill("timeout", 32'h0000_600C, -1, TimeoutCycles + 2, 32'h0, 1'b1);
        chk("timeout_data", bus.fill_data, 128'h0);
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("late_ready_data", bus.fill_data, 128'h0);
        chk("late_ready_error", bus.fill_error, 1'b1);
        chk("late_ready_addr", bus.fill_addr, 32'h6000);
`endif

        // Reset while WAITing on a memory that never answers.
        wait_idle();
        mem_delay      = -1;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h7004;
        @(negedge clk);
        bus.miss_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_miss_ready", bus.miss_ready, 1'b1);
        chk("midrst_mem_address", bus.mem_address, 32'h0);
        chk("midrst_fill_data", bus.fill_data, 128'h0);
        rst         = 1'b0;
        force_ready = 1'b1;
        repeat (4) @(negedge clk);
        refill("post_reset", 32'h0000_7008, 1, 4, 32'h7002, 1'b0);

        noise = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(3)) @(negedge clk);
            mem_delay      = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(6));
            bus.miss_valid = 1'b1;
            bus.miss_addr  = $urandom;
            g = 0;
            do begin
                acc = bus.miss_ready;
                @(negedge clk);
                g++;
            end while (!acc && g < 300);
            if (!acc) chk("rand_accept", bus.miss_ready, 1'b1);
            bus.miss_valid = 1'b0;
        end
        noise = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_refill_unit.md
# cache_refill_unit

- Miss-handling stage directly upstream of `main_memory`.
- Accepts one block-miss request at a time from the cache controller and issues a single-cycle `read_en` pulse with the block-aligned address.
- Waits for the memory's `ready`, captures the 128-bit block, then presents it to the cache with the requested word already selected.
- Optional watchdog terminates a refill the memory never answers.

## Interface
- `TIMEOUT_CYCLES`, 15: max WAIT cycles before abort (watchdog build only); legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `miss_valid`  in  1  controller requests a refill.
- `miss_addr`  in  32  byte address of the missing access.
- `miss_ready`  out  1  unit idle; a request is accepted on an edge where `miss_valid && miss_ready`.
- `mem_read_en`  out  1  read strobe to `main_memory`.
- `mem_address`  out  32  block-aligned address to memory.
- `mem_block_in`  in  128  block from memory; word i in bits [i*32+31:i*32].
- `mem_ready`  in  1  memory data valid this cycle.
- `fill_valid`  out  1  one-cycle strobe: fill outputs valid.
- `fill_addr`  out  32  block-aligned address of the fill.
- `fill_data`  out  128  captured block.
- `fill_word`  out  32  word selected by captured `miss_addr[3:2]`.
- `fill_error`  out  1  qualifies `fill_valid`: refill timed out, data invalid.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE → REQ on accept. Latch `{miss_addr[31:4],4'h0}` into the address register and `miss_addr[3:2]` into the word-select register.
  - REQ → WAIT unconditionally. `mem_read_en` = 1 only in REQ. `mem_address` is driven from the latched address in all states.
  - WAIT → FILL when `mem_ready` = 1. Capture `mem_block_in` into `fill_data`.
  - WAIT → FILL with error when the wait counter reaches `TIMEOUT_CYCLES` (watchdog build). `fill_data` is cleared to 0.
  - FILL → IDLE unconditionally. `fill_valid` = 1 only in FILL.
- Wait counter: 8 bits, cleared on entry to WAIT, increments each WAIT cycle without `mem_ready`. If `mem_ready` and the counter limit coincide, `mem_ready` wins and there is no error.
- `fill_word` = `fill_data[sel*32 +: 32]`; `fill_addr` = latched aligned address. Both are held stable from FILL until the next accept.
- `miss_valid` outside IDLE is ignored; the controller must hold the request until `miss_ready`.
- `mem_ready` seen in IDLE, REQ or FILL is ignored. This covers late data after a timeout.
- `rst` in any state → IDLE on that edge. Reset values:
  - `miss_ready` = 1
  - `mem_read_en`, `fill_valid`, `fill_error`, `busy` = 0
  - `mem_address`, `fill_addr`, `fill_data`, `fill_word` = 0
  - counter = 0

## Timing
- Accept at edge E0: REQ during cycle 1, so memory samples `read_en` at E1; `mem_ready` is high during cycle 2 (WAIT) and captured at E2; `fill_valid` is high during cycle 3. Request-to-fill latency is 3 cycles for a zero-wait memory.
- A stalled memory adds one cycle per WAIT cycle without `mem_ready`.
- `miss_ready` returns high the cycle after FILL. The minimum interval between accepts is 4 cycles.
- `mem_read_en` is never high for more than one consecutive cycle.

## Configuration
- `REFILL_TIMEOUT_EN` defined: the watchdog counter and the WAIT → FILL-with-error path are compiled in.
- Undefined: WAIT exits only on `mem_ready`, `fill_error` is tied 0, and `TIMEOUT_CYCLES` is unused.

## Test plan
- Basic refill: reset, then `miss_addr`=0x0000_1234 with the model memory.
  - `mem_read_en` pulses exactly once with `mem_address`=0x0000_1230.
  - `fill_valid` is high 3 cycles after accept with `fill_data`={0x1233,0x1232,0x1231,0x1230}, `fill_word`=0x1231, `fill_addr`=0x1230, `fill_error`=0.
- Word select sweep: addresses 0x40, 0x44, 0x48, 0x4C → `fill_word` = 0x40, 0x41, 0x42, 0x43.
- Stall: memory delays `mem_ready` by 5 cycles → `fill_valid` at 8 cycles after accept, correct data, no error, `busy` high throughout.
- Timeout (`REFILL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): memory never responds → `fill_valid` with `fill_error`=1 and `fill_data`=0. A later `mem_ready` pulse in IDLE leaves the outputs unchanged.
- Back-to-back and ignored request: `miss_valid` held continuously with 0x100 then 0x200 → two refills 4 cycles apart. A `miss_valid` raised during WAIT is not accepted until IDLE.
- Reset mid-operation: assert `rst` in WAIT → next cycle IDLE with all outputs at reset values. A subsequent `mem_ready` produces no `fill_valid`, and a new miss completes normally.
